// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell sequenced LSB-first, one bit per clock,
// with registered sum/c_out and a one-cycle done pulse on completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             load, step, last;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_s),
    .c_out (fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    next = IDLE;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE: begin
        next = IDLE;
        if (start) begin
          load = 1'b1;
          next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        next = last ? DONE : RUN;
      end
      DONE: begin
        if (start) begin
          load = 1'b1;
          next = RUN;
        end
      end
      default: next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so outputs never see inputs combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      c_out  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= next;
      busy  <= (next == RUN);
      done  <= (next == DONE);
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= c_in;
        cnt    <= '0;
        res_sh <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= fa_co;
        res_sh <= {fa_s, res_sh[WIDTH-1:1]};
        // Counter parks at WIDTH-1 on the final bit instead of wrapping.
        if (!last) cnt <= cnt + CW'(1);
        if (last) begin
          sum   <= {fa_s, res_sh[WIDTH-1:1]};
          c_out <= fa_co;
        end
      end
    end
  end
endmodule
